// File: rtl/reset_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : reset_sequencer_if
// Description : Request/status bundle between the reset sequencer and the SoC.
// Revision    : 1.0 - initial release
// ============================================================================
interface reset_sequencer_if #(
    parameter int N_CH = 3
) ();
    logic            sw_rst_req;
    logic            wdt_en;
    logic            wdt_kick;
    logic [N_CH-1:0] rst_out;
    logic            ready;
    logic [1:0]      reset_cause;
    logic [7:0]      reset_count;

    modport master (
        output sw_rst_req, wdt_en, wdt_kick,
        input  rst_out, ready, reset_cause, reset_count
    );

    modport slave (
        input  sw_rst_req, wdt_en, wdt_kick,
        output rst_out, ready, reset_cause, reset_count
    );
endinterface
`default_nettype wire

// File: rtl/reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : reset_sequencer
// Description : Staggered per-domain reset generator with warm reset, watchdog,
//               reset-cause record and saturating warm-reset counter.
// Revision    : 1.0 - initial release
// ============================================================================
module reset_sequencer #(
    parameter int N_CH        = 3,
    parameter int STRETCH     = 16,
    parameter int STAGGER     = 4,
    parameter int WDT_TIMEOUT = 200
) (
    input  wire logic          clk,
    input  wire logic          rst,
    reset_sequencer_if.slave   bus
);
    localparam int c_CNT_MAX = (STRETCH > STAGGER) ? STRETCH : STAGGER;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX);
    localparam int c_WDT_W   = $clog2(WDT_TIMEOUT);

    localparam logic [c_CNT_W-1:0] c_STRETCH_LAST = c_CNT_W'(STRETCH - 1);
    localparam logic [c_CNT_W-1:0] c_STAGGER_LAST = c_CNT_W'(STAGGER - 1);
    localparam logic [c_WDT_W-1:0] c_WDT_LAST     = c_WDT_W'(WDT_TIMEOUT - 1);

    localparam logic [1:0] c_CAUSE_COLD = 2'b01;
    localparam logic [1:0] c_CAUSE_WARM = 2'b10;
    localparam logic [1:0] c_CAUSE_WDT  = 2'b11;

    typedef enum logic [1:0] {
        S_ASSERT  = 2'd0,
        S_RELEASE = 2'd1,
        S_RUN     = 2'd2
    } state_t;

    state_t               state_q;
    logic [1:0]           sync_q;
    logic [c_CNT_W-1:0]   cnt_q;
    logic [c_WDT_W-1:0]   wdt_cnt_q;
    logic [c_WDT_W-1:0]   wdt_cnt_d;
    logic [N_CH-1:0]      rst_out_q;
    logic                 ready_q;
    logic [1:0]           cause_q;
    logic [7:0]           count_q;

    logic                 w_wdt_fire;
    logic                 w_sw_evt;
    logic                 w_warm_evt;
    logic [N_CH-1:0]      w_rst_out_next;

    // Kick has priority over expiry; the counter only advances in RUN.
    always_comb begin
        wdt_cnt_d  = '0;
        w_wdt_fire = 1'b0;
        if (state_q == S_RUN && bus.wdt_en) begin
            if (bus.wdt_kick) begin
                wdt_cnt_d = '0;
            end else if (wdt_cnt_q == c_WDT_LAST) begin
                w_wdt_fire = 1'b1;
            end else begin
                wdt_cnt_d = wdt_cnt_q + 1'b1;
            end
        end
        w_sw_evt   = bus.sw_rst_req && (state_q == S_RELEASE || state_q == S_RUN);
        w_warm_evt = w_wdt_fire || w_sw_evt;
    end

    // Channels release lowest index first, so a zero-filling left shift clears the next one.
    assign w_rst_out_next = rst_out_q << 1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_ASSERT;
            sync_q    <= 2'b11;
            cnt_q     <= '0;
            wdt_cnt_q <= '0;
            rst_out_q <= '1;
            ready_q   <= 1'b0;
            cause_q   <= c_CAUSE_COLD;
            count_q   <= 8'd0;
        end else begin
            sync_q    <= {sync_q[0], 1'b0};
            wdt_cnt_q <= wdt_cnt_d;
            if (w_warm_evt) begin
                state_q   <= S_ASSERT;
                cnt_q     <= '0;
                wdt_cnt_q <= '0;
                rst_out_q <= '1;
                ready_q   <= 1'b0;
                cause_q   <= w_wdt_fire ? c_CAUSE_WDT : c_CAUSE_WARM;
                if (count_q != 8'hFF) begin
                    count_q <= count_q + 8'd1;
                end
            end else begin
                case (state_q)
                    S_ASSERT: begin
                        if (!sync_q[1]) begin
                            if (cnt_q == c_STRETCH_LAST) begin
                                cnt_q     <= '0;
                                rst_out_q <= w_rst_out_next;
                                if (N_CH == 1) begin
                                    state_q <= S_RUN;
                                    ready_q <= 1'b1;
                                end else begin
                                    state_q <= S_RELEASE;
                                end
                            end else begin
                                cnt_q <= cnt_q + 1'b1;
                            end
                        end
                    end
                    S_RELEASE: begin
                        if (cnt_q == c_STAGGER_LAST) begin
                            cnt_q     <= '0;
                            rst_out_q <= w_rst_out_next;
                            if (w_rst_out_next == '0) begin
                                state_q <= S_RUN;
                                ready_q <= 1'b1;
                            end
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    S_RUN: begin
                        state_q <= S_RUN;
                    end
                    default: begin
                        state_q <= S_ASSERT;
                    end
                endcase
            end
        end
    end

    assign bus.rst_out     = rst_out_q;
    assign bus.ready       = ready_q;
    assign bus.reset_cause = cause_q;
    assign bus.reset_count = count_q;
endmodule
`default_nettype wire

// File: tb/tb_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_reset_sequencer
// Description : Scoreboard bench; an event-time reference model predicts outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reset_sequencer;
    localparam int N_CH        = 3;
    localparam int STRETCH     = 16;
    localparam int STAGGER     = 4;
    localparam int WDT_TIMEOUT = 32;

    typedef struct packed {
        logic [N_CH-1:0] ro;
        logic            rdy;
        logic [1:0]      cause;
        logic [7:0]      cnt;
    } exp_t;

    localparam exp_t c_RESET_EXP = '{ro: 3'b111, rdy: 1'b0, cause: 2'b01, cnt: 8'd0};

    logic clk;
    logic rst;
    int   nvec;
    int   nmis;
    exp_t sb_q[$];

    reset_sequencer_if #(.N_CH(N_CH)) bus ();

    reset_sequencer #(
        .N_CH        (N_CH),
        .STRETCH     (STRETCH),
        .STAGGER     (STAGGER),
        .WDT_TIMEOUT (WDT_TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: e counts edges since rst fell; channel i releases at t_rel0 + i*STAGGER.
    int m_e, m_rel0, m_run, m_clear, m_count;
    logic [1:0] m_cause;
    always @(posedge clk) begin
        exp_t x;
        int   p;
        bit   in_rel, in_run, wdt_ev, sw_ev;
        if (rst) begin
            m_e     = 0;
            m_rel0  = 2 + STRETCH;
            m_run   = m_rel0 + (N_CH - 1) * STAGGER;
            m_clear = 0;
            m_cause = 2'b01;
            m_count = 0;
        end else begin
            m_e    = m_e + 1;
            p      = m_e - 1;
            in_rel = (p >= m_rel0) && (p < m_run);
            in_run = (p >= m_run);
            wdt_ev = in_run && bus.wdt_en && !bus.wdt_kick && (m_e - m_clear == WDT_TIMEOUT);
            sw_ev  = bus.sw_rst_req && (in_rel || in_run);
            if (!(in_run && bus.wdt_en) || bus.wdt_kick) m_clear = m_e;
            if (wdt_ev || sw_ev) begin
                m_cause = wdt_ev ? 2'b11 : 2'b10;
                m_count = (m_count < 255) ? m_count + 1 : 255;
                m_rel0  = m_e + STRETCH;
                m_run   = m_rel0 + (N_CH - 1) * STAGGER;
                m_clear = m_e;
            end
        end
        for (int i = 0; i < N_CH; i++) x.ro[i] = (m_e < m_rel0 + i * STAGGER);
        x.rdy   = (m_e >= m_run);
        x.cause = m_cause;
        x.cnt   = 8'(m_count);
        sb_q.push_back(x);
    end

    // Monitor: the DUT presents a fresh output set every cycle.
    always @(negedge clk) begin
        exp_t x;
        exp_t a;
        a = '{ro: bus.rst_out, rdy: bus.ready, cause: bus.reset_cause, cnt: bus.reset_count};
        nvec = nvec + 1;
        if (sb_q.size() == 0) begin
            nmis = nmis + 1;
            $display("FAIL scoreboard_empty t=%0t got=%h expected an entry", $time, a);
        end else begin
            x = sb_q.pop_front();
            if (rst) x = c_RESET_EXP;
            if (a !== x) begin
                nmis = nmis + 1;
                $display("FAIL outputs t=%0t got rst_out=%b ready=%b cause=%b count=%0d, need rst_out=%b ready=%b cause=%b count=%0d",
                         $time, a.ro, a.rdy, a.cause, a.cnt, x.ro, x.rdy, x.cause, x.cnt);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic sw_pulse();
        bus.sw_rst_req = 1'b1;
        tick(1);
        bus.sw_rst_req = 1'b0;
    endtask

    task automatic kick_pulse();
        bus.wdt_kick = 1'b1;
        tick(1);
        bus.wdt_kick = 1'b0;
    endtask

    initial begin
        nvec           = 0;
        nmis           = 0;
        rst            = 1'b1;
        bus.sw_rst_req = 1'b0;
        bus.wdt_en     = 1'b0;
        bus.wdt_kick   = 1'b0;

        // Cold boot
        tick(5);
        rst = 1'b0;
        tick(30);

        // Warm reset from RUN
        sw_pulse();
        tick(30);

        // Watchdog expiry with no kick, then regular servicing
        bus.wdt_en = 1'b1;
        tick(70);
        for (int i = 0; i < 50; i++) begin
            kick_pulse();
            tick(19);
        end

        // Kick landing exactly on the expiry cycle
        kick_pulse();
        tick(WDT_TIMEOUT - 1);
        kick_pulse();
        tick(10);

        // Watchdog expiry coinciding with a software request
        kick_pulse();
        tick(WDT_TIMEOUT - 1);
        sw_pulse();
        bus.wdt_en = 1'b0;
        tick(30);

        // Async reset mid-release while rst_out=110
        sw_pulse();
        tick(STRETCH + 1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(30);

        // Software request during ASSERT is ignored
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(5);
        sw_pulse();
        tick(40);

        // Software request during RELEASE (rst_out=100) restarts the sequence
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(2 + STRETCH + STAGGER);
        sw_pulse();
        tick(30);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            bus.sw_rst_req = ($urandom_range(0, 99) < 2);
            bus.wdt_kick   = ($urandom_range(0, 99) < 4);
            if ($urandom_range(0, 99) < 2) bus.wdt_en = ~bus.wdt_en;
            tick(1);
        end
        bus.sw_rst_req = 1'b0;
        bus.wdt_kick   = 1'b0;
        bus.wdt_en     = 1'b0;
        tick(40);

        // Counter saturation
        for (int i = 0; i < 300; i++) begin
            sw_pulse();
            tick(STRETCH + 1);
        end
        tick(30);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
`default_nettype wire
